tx_prbs_gen: RTL
================

# tx_prbs_gen

Serial test-data source for the transmit path. It produces one bit per `clk` cycle on `out`. That bit drives the `in` input of the transmit FIR driver, which applies the pre-emphasis taps. The block offers standard PRBS patterns, a clock pattern and a user word, plus seed load, gating, single-bit error injection and an emitted-bit counter for BER measurement downstream.

## Interface
- Parameters:
- `USER_WIDTH`, default 32: length of the user pattern word.
- `CNT_WIDTH`, default 32: width of the emitted-bit counter.
- Ports:
- `clk`  in  1  transmit bit clock; one bit per rising edge.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low.**
- `en`  in  1  advance enable; when low, the generator holds.
- `load`  in  1  single-cycle strobe that samples `mode`, `seed` and `user_word`.
- `mode`  in  3  pattern select (`PRBS_MODE` enum): 0 PRBS7, 1 PRBS9, 2 PRBS15, 3 PRBS31, 4 CLK, 5 USER; values 6–7 are treated as PRBS7.
- `seed`  in  31  LFSR seed; only the low N bits are used for PRBSN.
- `user_word`  in  USER_WIDTH  pattern for USER mode, sent MSB first.
- `inj_err`  in  1  invert the next emitted bit.
- `out`  out  1  serial bit to the TX driver; registered.
- `bit_cnt`  out  CNT_WIDTH  count of emitted bits; saturates at all-ones.
- `err_cnt`  out  16  count of injected errors; saturates.

## Operation
- **Active mode register.** `mode` is sampled only on `load`; changes to `mode` at any other time are ignored.
- **LFSR form.** Fibonacci, 31-bit state `s`. Each enabled cycle: `fb = s[t1-1] ^ s[t2-1]`, `s <= {s[29:0], fb}` (masked to N bits), emitted bit = `fb`.
- **Taps (t1, t2):** PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS31 (31,28).
- **Zero-seed guard.** On `load`, if the low N bits of `seed` are zero, the state loads all-ones.
- **CLK mode.** Alternates 1,0,1,0… The first bit after `load` is 1.
- **USER mode.** Rotates `user_word` left and emits the MSB. After `USER_WIDTH` bits the word repeats.
- **Emitted bit.** `out <= gen_bit ^ err_pend`, where `gen_bit` is the pattern bit for the cycle.
- **Error pending flag.** `err_pend` is set by `inj_err` in any cycle. It is cleared by the next enabled emit, which also increments `err_cnt`. Repeated `inj_err` pulses before an emit merge into one error. LFSR state is never affected by injection.
- **Enable low.** State, `out` and the counters hold.
- **Load cycle.** `load` has priority over `en`. The load cycle writes state and holds `out`; `bit_cnt` is not incremented. `load` does not clear `bit_cnt`, `err_cnt` or `err_pend`.
- **`load` together with `inj_err`.** The injected error applies to the first bit after the load.
- **Counter update.** `bit_cnt` increments on each enabled non-load cycle.

## Timing
- **Reset values:** `out`=0, `bit_cnt`=0, `err_cnt`=0, `err_pend`=0, active mode PRBS7, state all-ones, user register 0.
- **Reset release.** The first edge with `en`=1 emits PRBS7 from the all-ones state.
- **Reset mid-operation.** Asynchronous: all registers go to their reset values immediately, independent of `clk`.
- **Latency.** With `load` high at edge n and `en` high at edge n+1, the first bit of the new pattern is visible on `out` after edge n+1.
- **No back-pressure.** The downstream driver consumes one bit per cycle.
- **Counter saturation.** Counters saturate: at all-ones they do not wrap.

## Structure
- **Add to `tx_package`:**
- the `PRBS_MODE` enum;
- per-mode tap constants `PRBS_TAP1[]` and `PRBS_TAP2[]`;
- length masks `PRBS_MASK[]`.
- **Sub-module `prbs_lfsr`.** Contains the 31-bit state, the mask/tap selection, the seed load and the zero-seed guard. The top level adds CLK/USER muxing, error injection and the counters.

## Test plan
- **Reset/enable.** Reset, then `en`=1 in PRBS7 → `out` = 0,0,0,0,0,0,1 for bits 1–7; the first 127 bits repeat exactly at bits 128–254; `bit_cnt`=254.
- **PRBS31.** `load` with mode 3 and `seed`=0 → state loads all-ones; run 2^16 bits and compare against a reference model bit-for-bit; no all-zero lockup.
- **Error injection.** PRBS15 stream, `inj_err` pulsed twice in one cycle window, then once more 10 bits later → exactly bits k and k+10 are inverted versus the reference model; `err_cnt`=2; the following sequence is unshifted.
- **Enable gating.** `en` low for 5 cycles mid-PRBS9, with an `inj_err` pulse during the stall → `out` and `bit_cnt` frozen; the first bit after resume is the next reference bit, inverted.
- **USER/CLK modes.** USER mode with `user_word`=0x80000001 → 1, thirty 0s, 1, then repeat. CLK mode → 1,0,1,0.
- **Async reset.** Assert `rst_n` low between clock edges mid-stream → outputs reach their reset values without a clock edge; the first enabled edge after release matches the reset-release sequence.

Source files
------------

// File: rtl/tx_package.sv
// Shared types and constants for the transmit test-pattern path.
package tx_package;

  // Pattern selector; raw codes 6 and 7 decode to PRBS7.
  typedef enum logic [2:0] {
    PRBS7     = 3'd0,
    PRBS9     = 3'd1,
    PRBS15    = 3'd2,
    PRBS31    = 3'd3,
    PRBS_CLK  = 3'd4,
    PRBS_USER = 3'd5
  } PRBS_MODE;

  // LFSR taps (1-based bit positions) and length masks, indexed by LFSR select:
  // 0 PRBS7, 1 PRBS9, 2 PRBS15, 3 PRBS31.
  localparam logic [4:0]  PRBS_TAP1 [4] = '{5'd7, 5'd9, 5'd15, 5'd31};
  localparam logic [4:0]  PRBS_TAP2 [4] = '{5'd6, 5'd5, 5'd14, 5'd28};
  localparam logic [30:0] PRBS_MASK [4] = '{31'h0000_007F, 31'h0000_01FF,
                                            31'h0000_7FFF, 31'h7FFF_FFFF};

  // Map the raw 3-bit mode input onto the enum, folding unused codes to PRBS7.
  function automatic PRBS_MODE prbs_mode_decode(input logic [2:0] raw);
    PRBS_MODE m;
    case (raw)
      3'd0:    m = PRBS7;
      3'd1:    m = PRBS9;
      3'd2:    m = PRBS15;
      3'd3:    m = PRBS31;
      3'd4:    m = PRBS_CLK;
      3'd5:    m = PRBS_USER;
      default: m = PRBS7;
    endcase
    return m;
  endfunction

  // LFSR table index for a mode; non-PRBS modes pick PRBS7 (their LFSR is idle).
  function automatic logic [1:0] lfsr_sel(input PRBS_MODE m);
    logic [1:0] s;
    case (m)
      PRBS9:   s = 2'd1;
      PRBS15:  s = 2'd2;
      PRBS31:  s = 2'd3;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tx_prbs_gen_lfsr.sv
// Fibonacci LFSR shared by all PRBS lengths: 31-bit state, per-length taps
// and mask, seed load with an all-zero guard.
module prbs_lfsr
  import tx_package::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,      // load seed (takes priority over advance)
  input  logic        adv_i,       // shift one step
  input  logic [1:0]  load_sel_i,  // length used for the seed being loaded
  input  logic [1:0]  run_sel_i,   // length currently running
  input  logic [30:0] seed_i,
  output logic        fb_o         // pattern bit for this cycle
);

  logic [30:0] s_q;
  logic [30:0] s_d;
  logic [30:0] seed_masked_s;
  logic [4:0]  tap1_idx_s;
  logic [4:0]  tap2_idx_s;
  logic        fb_s;

  // Feedback bit from the two taps of the running length.
  always_comb begin
    tap1_idx_s = PRBS_TAP1[run_sel_i] - 5'd1;
    tap2_idx_s = PRBS_TAP2[run_sel_i] - 5'd1;
    fb_s       = s_q[tap1_idx_s] ^ s_q[tap2_idx_s];
  end

  // Next state: seed load (zero seed replaced by all-ones), shift, or hold.
  always_comb begin
    seed_masked_s = seed_i & PRBS_MASK[load_sel_i];
    s_d           = s_q;
    if (load_i) begin
      if (seed_masked_s == 31'd0) begin
        s_d = PRBS_MASK[load_sel_i];
      end else begin
        s_d = seed_masked_s;
      end
    end else if (adv_i) begin
      s_d = {s_q[29:0], fb_s} & PRBS_MASK[run_sel_i];
    end else begin
      s_d = s_q;
    end
  end

  // State register; resets to all-ones so PRBS7 runs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 31'h7FFF_FFFF;
    end else begin
      s_q <= s_d;
    end
  end

  assign fb_o = fb_s;

endmodule

// File: rtl/tx_prbs_gen.sv
// Serial test-data source for the TX FIR driver: PRBS7/9/15/31, clock
// pattern, user word, single-bit error injection and emitted/error counters.
module tx_prbs_gen
  import tx_package::*;
#(
  parameter int unsigned USER_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [2:0]            mode,
  input  logic [30:0]           seed,
  input  logic [USER_WIDTH-1:0] user_word,
  input  logic                  inj_err,
  output logic                  out,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic [15:0]           err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  PRBS_MODE              mode_q, mode_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  clk_ph_q, clk_ph_d;
  logic                  out_q, out_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  err_pend_q, err_pend_d;

  logic                  emit_s;
  logic                  gen_bit_s;
  logic                  lfsr_adv_s;
  logic                  lfsr_fb_s;

  // load wins over en, so a load cycle never emits.
  assign emit_s = en & ~load;

  prbs_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .adv_i      (lfsr_adv_s),
    .load_sel_i (lfsr_sel(prbs_mode_decode(mode))),
    .run_sel_i  (lfsr_sel(mode_q)),
    .seed_i     (seed),
    .fb_o       (lfsr_fb_s)
  );

  // Select this cycle's pattern bit; the LFSR only steps in PRBS modes.
  always_comb begin
    gen_bit_s  = lfsr_fb_s;
    lfsr_adv_s = 1'b0;
    case (mode_q)
      PRBS_CLK: begin
        gen_bit_s  = clk_ph_q;
        lfsr_adv_s = 1'b0;
      end
      PRBS_USER: begin
        gen_bit_s  = user_q[USER_WIDTH-1];
        lfsr_adv_s = 1'b0;
      end
      default: begin
        gen_bit_s  = lfsr_fb_s;
        lfsr_adv_s = emit_s;
      end
    endcase
  end

  // Next-state for mode, pattern registers, output bit, error flag and counters.
  always_comb begin
    mode_d     = mode_q;
    user_d     = user_q;
    clk_ph_d   = clk_ph_q;
    out_d      = out_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_pend_d = err_pend_q;
    if (load) begin
      // Load keeps out and counters; a pending error survives for the next bit.
      mode_d     = prbs_mode_decode(mode);
      user_d     = user_word;
      clk_ph_d   = 1'b1;
      err_pend_d = err_pend_q | inj_err;
    end else if (en) begin
      out_d      = gen_bit_s ^ err_pend_q;
      // An inj_err seen on an emit edge targets the following bit.
      err_pend_d = inj_err;
      if (mode_q == PRBS_CLK) begin
        clk_ph_d = ~clk_ph_q;
      end else begin
        clk_ph_d = clk_ph_q;
      end
      if (mode_q == PRBS_USER) begin
        user_d = {user_q[USER_WIDTH-2:0], user_q[USER_WIDTH-1]};
      end else begin
        user_d = user_q;
      end
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
      if (err_pend_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_pend_d = err_pend_q | inj_err;
    end
  end

  // Registers; reset leaves PRBS7 active with the LFSR at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= PRBS7;
      user_q     <= {USER_WIDTH{1'b0}};
      clk_ph_q   <= 1'b1;
      out_q      <= 1'b0;
      bit_cnt_q  <= {CNT_WIDTH{1'b0}};
      err_cnt_q  <= 16'd0;
      err_pend_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      user_q     <= user_d;
      clk_ph_q   <= clk_ph_d;
      out_q      <= out_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign out     = out_q;
  assign bit_cnt = bit_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
